// File: rtl/muon_pkg.sv
// muon_pkg: shared state encoding, clock rate and saturating-count helper for muon timing blocks
package muon_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_TIMING  = 2'd1;
  localparam logic [1:0] ST_REPORT  = 2'd2;
  localparam logic [1:0] ST_HOLDOFF = 2'd3;
  localparam int CLK_HZ = 100_000_000;
  localparam int TIME_W_DEF = 16;
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return c + {15'd0, ~&c};
  endfunction
endpackage

// File: rtl/muon_decay_sequencer_if.sv
// muon_decay_sequencer_if: valid/ready result stream carrying the measured interval
interface muon_decay_sequencer_if #(parameter int TIME_W = 16);
  logic              result_valid;
  logic              result_ready;
  logic [TIME_W-1:0] result_time;
  modport master (output result_valid, result_time, input result_ready);
  modport slave  (input result_valid, result_time, output result_ready);
endinterface

// File: rtl/holdoff_timer.sv
// holdoff_timer: loadable down-counter; done flags the last cycle of the loaded dwell
module holdoff_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         count,
  input  logic [W-1:0] value,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else     cnt <= load ? value : (count && cnt != '0) ? cnt - 1'b1 : cnt;
  assign done = cnt == W'(1);
endmodule

// File: rtl/muon_decay_sequencer.sv
// muon_decay_sequencer: times muon stop-to-decay gaps, streams the interval out, then holds off
module muon_decay_sequencer
  import muon_pkg::*;
#(
  parameter int          WINDOW_CYCLES  = 2000,
  parameter int          HOLDOFF_CYCLES = 10,
  parameter int          TIME_W         = TIME_W_DEF,
  parameter logic [15:0] COUNT_INIT     = 16'd0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_event,
  input  logic                   stop_event,
  muon_decay_sequencer_if.master res,
  output logic                   busy,
  output logic                   enable_A,
  output logic                   enable_B,
  output logic [15:0]            event_count,
  output logic [15:0]            timeout_count
);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  logic [1:0]        state;
  logic [TIME_W-1:0] timer;
  logic [TIME_W-1:0] result_time;
  logic              at_window;
  logic              hold_load;
  logic              hold_done;
  assign at_window = timer == TIME_W'(WINDOW_CYCLES);
  // holdoff starts on either a timeout or a completed handshake
  assign hold_load = (state == ST_TIMING && !stop_event && at_window) ||
                     (state == ST_REPORT && res.result_ready);
  holdoff_timer #(.W(HW)) u_holdoff (
    .clk   (clk),
    .rst   (rst),
    .load  (hold_load),
    .count (state == ST_HOLDOFF),
    .value (HW'(HOLDOFF_CYCLES)),
    .done  (hold_done)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state         <= ST_IDLE;
      timer         <= '0;
      result_time   <= '0;
      event_count   <= COUNT_INIT;
      timeout_count <= COUNT_INIT;
    end else begin
      case (state)
        ST_IDLE:
          if (start_event) begin
            state <= ST_TIMING;
            timer <= TIME_W'(1);
          end
        ST_TIMING:
          if (stop_event) begin
            result_time <= timer;
            event_count <= sat_inc(event_count);
            state       <= ST_REPORT;
          end else if (at_window) begin
            timeout_count <= sat_inc(timeout_count);
            state         <= ST_HOLDOFF;
          end else timer <= timer + 1'b1;
        ST_REPORT:
          if (res.result_ready) state <= ST_HOLDOFF;
        default:
          if (hold_done) state <= ST_IDLE;
      endcase
    end
  assign res.result_valid = state == ST_REPORT;
  assign res.result_time  = result_time;
  assign busy             = state != ST_IDLE;
  assign enable_A         = state == ST_IDLE;
  assign enable_B         = state == ST_TIMING;
endmodule

// File: tb/tb_muon_decay_sequencer.sv
// tb_muon_decay_sequencer: directed checks of measurement, timeout, backpressure, reset and saturation
module tb_muon_decay_sequencer;
  localparam int WIN  = 20;
  localparam int HOLD = 10;
  logic clk = 0, rst = 1, start_event = 0, stop_event = 0;
  logic busy, enable_A, enable_B, s_busy, s_a, s_b;
  logic [15:0] event_count, timeout_count, s_ev, s_to;
  int vectors = 0, miscompares = 0, hs = 0, exp_hs = 0, exp_ev = 0, exp_to = 0;
  muon_decay_sequencer_if #(.TIME_W(16)) rif ();
  muon_decay_sequencer_if #(.TIME_W(16)) sif ();
  muon_decay_sequencer #(.WINDOW_CYCLES(WIN), .HOLDOFF_CYCLES(HOLD), .TIME_W(16)) dut (
    .clk(clk), .rst(rst), .start_event(start_event), .stop_event(stop_event), .res(rif.master),
    .busy(busy), .enable_A(enable_A), .enable_B(enable_B),
    .event_count(event_count), .timeout_count(timeout_count));
  // counters preloaded near the top so saturation is reached in a few measurements
  muon_decay_sequencer #(.WINDOW_CYCLES(WIN), .HOLDOFF_CYCLES(HOLD), .TIME_W(16), .COUNT_INIT(16'hFFFD)) sat (
    .clk(clk), .rst(rst), .start_event(start_event), .stop_event(stop_event), .res(sif.master),
    .busy(s_busy), .enable_A(s_a), .enable_B(s_b),
    .event_count(s_ev), .timeout_count(s_to));
  always #5 clk = ~clk;
  always @(posedge clk) if (rif.result_valid && rif.result_ready) hs++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic hold_wait();
    repeat (HOLD - 1) tick();
    check("hold_busy", busy, 1);
    tick();
    check("rearm", {busy, enable_A, enable_B}, 3'b010);
  endtask
  task automatic meas(input int k, input bit both);
    start_event = 1;
    stop_event  = both;
    tick();
    start_event = 0;
    stop_event  = 0;
    check("arm", {busy, enable_A, enable_B}, 3'b101);
    repeat (k - 1) tick();
    stop_event = 1;
    tick();
    stop_event = 0;
    exp_ev++;
    check("valid", rif.result_valid, 1);
    check("rtime", rif.result_time, k);
    check("ev", event_count, exp_ev);
    if (rif.result_ready) begin
      tick();
      exp_hs++;
      check("hs", hs, exp_hs);
      check("vdrop", {rif.result_valid, busy}, 2'b01);
      hold_wait();
    end
  endtask
  task automatic tmo();
    start_event = 1;
    tick();
    start_event = 0;
    repeat (WIN) tick();
    exp_to++;
    check("to", timeout_count, exp_to);
    check("to_state", {rif.result_valid, busy, enable_B}, 3'b010);
    hold_wait();
  endtask
  task automatic reset_values();
    check("rst_out", {rif.result_valid, busy, enable_A, enable_B}, 4'b0010);
    check("rst_time", rif.result_time, 0);
    check("rst_cnt", {event_count, timeout_count}, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    rif.result_ready = 1;
    sif.result_ready = 1;
    repeat (2) tick();
    reset_values();
    @(negedge clk) rst = 0;
    tick();
    repeat (5) tick();
    meas(7, 0);
    start_event = 1;
    tick();
    start_event = 0;
    repeat (WIN) tick();
    exp_to++;
    check("tmo", timeout_count, exp_to);
    check("tmo_state", {rif.result_valid, busy, enable_B}, 3'b010);
    repeat (2) tick();
    start_event = 1;
    tick();
    start_event = 0;
    repeat (HOLD - 4) tick();
    check("tmo_hold", busy, 1);
    tick();
    check("tmo_rearm", {busy, event_count}, {1'b0, 16'd1});
    meas(1, 0);
    meas(WIN, 1);
    start_event = 1;
    tick();
    start_event = 0;
    repeat (WIN) tick();
    stop_event = 1;
    tick();
    stop_event = 0;
    exp_to++;
    check("k21", {rif.result_valid, busy, timeout_count}, {2'b01, 16'(exp_to)});
    repeat (HOLD - 2) tick();
    check("k21_hold", busy, 1);
    tick();
    check("k21_rearm", busy, 0);
    rif.result_ready = 0;
    meas(5, 0);
    for (int i = 0; i < 30; i++) begin
      start_event = i == 10;
      stop_event  = i == 12;
      tick();
      check("bp_hold", {rif.result_valid, rif.result_time}, {1'b1, 16'd5});
    end
    start_event = 0;
    stop_event  = 0;
    rif.result_ready = 1;
    tick();
    exp_hs++;
    check("bp_hs", {hs, 31'(rif.result_valid)}, {exp_hs, 31'd0});
    check("bp_cnt", {event_count, timeout_count}, {16'(exp_ev), 16'(exp_to)});
    hold_wait();
    start_event = 1;
    tick();
    start_event = 0;
    repeat (3) tick();
    #3 rst = 1;
    #1 reset_values();
    @(negedge clk) rst = 0;
    tick();
    exp_ev = 0;
    exp_to = 0;
    rif.result_ready = 0;
    meas(3, 0);
    #2 rst = 1;
    #1 reset_values();
    check("rst_nohs", hs, exp_hs);
    rif.result_ready = 1;
    @(negedge clk) rst = 0;
    tick();
    check("rst_nohs2", hs, exp_hs);
    exp_ev = 0;
    repeat (4) meas(2, 0);
    repeat (3) tmo();
    check("main_cnt", {event_count, timeout_count}, {16'd4, 16'd3});
    check("sat_ev", s_ev, 16'hFFFF);
    check("sat_to", s_to, 16'hFFFF);
    check("sat_state", {s_busy, s_a, s_b, sif.result_time}, {3'b010, 16'd2});
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
